// File: rtl/pps_pin_receiver.sv
// PPS pin receive path: synchronise and glitch-filter the IOBUF output, strobe accepted
// rising edges, and qualify the edge-to-edge period against CLK_HZ +/- TOL.
module pps_pin_receiver #(
    parameter int unsigned CLK_HZ    = 250_000_000,
    parameter int unsigned TOL       = 1000,
    parameter int unsigned MIN_WIDTH = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pos0,
    input  logic             pos1,
    input  logic             pin_in,
    output logic             pps_pulse,
    output logic             pps_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_err,
    output logic             pps_missing,
    output logic [7:0]       glitch_cnt
);

    localparam int unsigned      RUN_W   = $clog2(MIN_WIDTH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_WIDTH);
    localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(MIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] LO_LIM  = (CLK_HZ > TOL) ? CNT_W'(CLK_HZ - TOL) : '0;
    localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(CLK_HZ + TOL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_SEARCH   = 2'd1;
    localparam logic [1:0] ST_ACQUIRE  = 2'd2;
    localparam logic [1:0] ST_LOCKED   = 2'd3;

    logic             rx_en;
    logic             sync1, sync2;
    logic             vld1, vld2;
    logic             armed;
    logic [RUN_W-1:0] run_cnt;
    logic             edge_acc;
    logic             glitch;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             in_tol;

    // vld1/vld2 track the synchroniser filling with real pin samples; armed is set only
    // by a genuine low, so a high run already in progress at reset release is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en    <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            vld1     <= 1'b0;
            vld2     <= 1'b0;
            armed    <= 1'b0;
            run_cnt  <= '0;
            edge_acc <= 1'b0;
            glitch   <= 1'b0;
        end else begin
            rx_en    <= pos0 | pos1;
            sync1    <= pin_in;
            sync2    <= sync1;
            vld1     <= 1'b1;
            vld2     <= vld1;
            edge_acc <= armed && sync2 && (run_cnt == RUN_ACC);
            glitch   <= armed && !sync2 && (run_cnt != '0) && (run_cnt < RUN_MAX);
            if (!sync2) begin
                run_cnt <= '0;
                if (vld2)
                    armed <= 1'b1;
            end else if (run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    assign in_tol = (cnt >= LO_LIM) && (cnt <= HI_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DISABLED;
            cnt         <= '0;
            pps_pulse   <= 1'b0;
            pps_valid   <= 1'b0;
            period_cnt  <= '0;
            period_err  <= 1'b0;
            pps_missing <= 1'b0;
            glitch_cnt  <= '0;
        end else begin
            pps_pulse   <= 1'b0;
            period_err  <= 1'b0;
            pps_missing <= 1'b0;
            if (!rx_en) begin
                state      <= ST_DISABLED;
                cnt        <= '0;
                pps_valid  <= 1'b0;
                period_cnt <= '0;
                glitch_cnt <= '0;
            end else begin
                if (state != ST_DISABLED) begin
                    pps_pulse <= edge_acc;
                    if (glitch && (glitch_cnt != 8'hFF))
                        glitch_cnt <= glitch_cnt + 8'd1;
                end
                if (edge_acc)
                    cnt <= CNT_ONE;
                else if (cnt != '1)
                    cnt <= cnt + CNT_ONE;
                case (state)
                    ST_DISABLED: state <= ST_SEARCH;
                    ST_SEARCH: begin
                        if (edge_acc)
                            state <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE, ST_LOCKED: begin
                        // An edge landing on the timeout cycle wins and sits at the upper limit.
                        if (edge_acc) begin
                            period_cnt <= cnt;
                            if (in_tol) begin
                                state     <= ST_LOCKED;
                                pps_valid <= 1'b1;
                            end else begin
                                state      <= ST_ACQUIRE;
                                pps_valid  <= 1'b0;
                                period_err <= 1'b1;
                            end
                        end else if (cnt == HI_LIM) begin
                            state       <= ST_SEARCH;
                            pps_valid   <= 1'b0;
                            pps_missing <= 1'b1;
                        end
                    end
                    default: state <= ST_DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pps_pin_receiver.sv
// Self-checking bench for pps_pin_receiver: directed scenarios plus randomized pulse trains,
// compared every cycle against a sample-history reference model.
module tb_pps_pin_receiver;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned TOL    = 10;
    localparam int unsigned W      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pos0 = 1'b0;
    logic        pos1 = 1'b0;
    logic        pin_in = 1'b0;
    logic        pps_pulse, pps_valid, period_err, pps_missing;
    logic [31:0] period_cnt;
    logic [7:0]  glitch_cnt;

    pps_pin_receiver #(
        .CLK_HZ(CLK_HZ),
        .TOL(TOL),
        .MIN_WIDTH(W),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pos0(pos0),
        .pos1(pos1),
        .pin_in(pin_in),
        .pps_pulse(pps_pulse),
        .pps_valid(pps_valid),
        .period_cnt(period_cnt),
        .period_err(period_err),
        .pps_missing(pps_missing),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // pin_s[k] is the pin level seen by the k-th rising clock edge.
    bit pin_s [0:65535];
    int n = -1;
    int r0 = 0;
    bit en_prev = 1'b0;

    int m_st = 0;   // 0 disabled, 1 search, 2 acquire, 3 locked
    int m_last = 0;
    bit m_pulse = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_miss = 1'b0;
    int m_period = 0, m_glitch = 0;

    int checks = 0, fails = 0;
    int last_pulse_n = -100, rise_n = 0;
    int seen_pulse = 0, seen_err = 0, seen_miss = 0;

    // Accepted edge strobed at edge idx: the pin rose at idx-W-2, stayed high W samples,
    // and the low before it was seen after reset release.
    function automatic bit acc_at(int idx);
        int k, j;
        if (idx < 3 || !pin_s[idx-3]) return 1'b0;
        k = 0;
        j = idx - 3;
        while (j >= 0 && pin_s[j] && k <= int'(W)) begin
            k++;
            j--;
        end
        return (k == int'(W)) && (j >= r0);
    endfunction

    function automatic bit glitch_at(int idx);
        int k, j;
        if (idx < 4 || pin_s[idx-3]) return 1'b0;
        k = 0;
        j = idx - 4;
        while (j >= 0 && pin_s[j] && k < int'(W)) begin
            k++;
            j--;
        end
        return (k >= 1) && (k < int'(W)) && (j >= r0);
    endfunction

    task automatic model_step(bit rst, bit en);
        bit e, g;
        int d;
        m_pulse = 1'b0;
        m_err   = 1'b0;
        m_miss  = 1'b0;
        if (!rst) begin
            m_st = 0; m_last = 0; m_valid = 1'b0; m_period = 0; m_glitch = 0;
            en_prev = 1'b0;
            r0 = n + 1;
        end else begin
            e = acc_at(n);
            g = glitch_at(n);
            if (!en_prev) begin
                m_st = 0; m_valid = 1'b0; m_period = 0; m_glitch = 0;
            end else begin
                if (m_st != 0) begin
                    m_pulse = e;
                    if (g && m_glitch < 255) m_glitch++;
                end
                case (m_st)
                    0: m_st = 1;
                    1: if (e) begin m_last = n; m_st = 2; end
                    default: begin
                        if (e) begin
                            d = n - m_last;
                            m_period = d;
                            m_last = n;
                            if (d >= int'(CLK_HZ - TOL) && d <= int'(CLK_HZ + TOL)) begin
                                m_st = 3; m_valid = 1'b1;
                            end else begin
                                m_st = 2; m_valid = 1'b0; m_err = 1'b1;
                            end
                        end else if (n - m_last == int'(CLK_HZ + TOL)) begin
                            m_st = 1; m_valid = 1'b0; m_miss = 1'b1;
                        end
                    end
                endcase
            end
            en_prev = en;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        pin_s[n] = pin_in;
        model_step(rst_n, pos0 | pos1);
        @(negedge clk);
        check("pps_pulse",   32'(pps_pulse),   32'(m_pulse));
        check("pps_valid",   32'(pps_valid),   32'(m_valid));
        check("period_cnt",  period_cnt,       32'(m_period));
        check("period_err",  32'(period_err),  32'(m_err));
        check("pps_missing", 32'(pps_missing), 32'(m_miss));
        check("glitch_cnt",  32'(glitch_cnt),  32'(m_glitch));
        if (pps_pulse) begin seen_pulse++; last_pulse_n = n; end
        if (period_err) seen_err++;
        if (pps_missing) seen_miss++;
    endtask

    // High for w cycles, optional mid-period glitch of gw cycles, rise-to-rise period p.
    task automatic pulse_glitch(int w, int p, int gw);
        rise_n = n + 1;
        pin_in = 1'b1;
        repeat (w) tick();
        pin_in = 1'b0;
        if (gw > 0) begin
            repeat (p / 2 - w) tick();
            pin_in = 1'b1;
            repeat (gw) tick();
            pin_in = 1'b0;
            repeat (p - p / 2 - gw) tick();
        end else begin
            repeat (p - w) tick();
        end
    endtask

    task automatic pulse_gap(int w, int p);
        pulse_glitch(w, p, 0);
    endtask

    initial begin
        int saved;
        repeat (3) tick();
        check("rst_valid",  32'(pps_valid), 32'd0);
        check("rst_period", period_cnt,     32'd0);
        rst_n = 1'b1;
        pos0  = 1'b1;
        repeat (5) tick();

        // Lock onto nominal pulses; latency rise->pps_pulse is MIN_WIDTH+2.
        pulse_gap(20, 1000);
        check("latency", 32'(last_pulse_n - rise_n), 32'd6);
        pulse_gap(20, 1000);
        check("valid_2nd",  32'(pps_valid), 32'd1);
        check("period_2nd", period_cnt,     32'd1000);
        pulse_gap(20, 1000);

        // Short glitch mid-period while locked.
        saved = seen_pulse;
        pulse_gap(20, 500);
        pin_in = 1'b1;
        repeat (2) tick();
        pin_in = 1'b0;
        repeat (498) tick();
        check("glitch_nopulse", 32'(seen_pulse - saved), 32'd1);
        pulse_gap(20, 1000);
        check("glitch_cnt1",  32'(glitch_cnt), 32'd1);
        check("glitch_valid", 32'(pps_valid),  32'd1);

        // Pulses stop: timeout, then re-acquire from SEARCH.
        seen_miss = 0;
        pulse_gap(20, 1100);
        check("miss_seen",  32'(seen_miss), 32'd1);
        check("miss_valid", 32'(pps_valid), 32'd0);
        pulse_gap(20, 1000);
        check("search_noupd", period_cnt, 32'd1000);
        pulse_gap(20, 1000);
        check("relock_valid", 32'(pps_valid), 32'd1);

        // Early edge while locked.
        pulse_gap(20, 950);
        seen_err = 0;
        pulse_gap(20, 1000);
        check("early_err",    32'(seen_err),  32'd1);
        check("early_valid",  32'(pps_valid), 32'd0);
        check("early_period", period_cnt,     32'd950);
        pulse_gap(20, 1000);
        check("early_relock", 32'(pps_valid), 32'd1);

        // Tolerance boundaries: 1010 (coincides with timeout), 990, then 989.
        pulse_gap(20, 1010);
        pulse_gap(20, 990);
        pulse_gap(20, 989);
        check("b1010_valid", 32'(pps_valid), 32'd1);
        pulse_gap(20, 1000);
        check("b989_period", period_cnt,     32'd989);
        check("b989_valid",  32'(pps_valid), 32'd0);

        // Width boundary: W-1 is a glitch, W is an edge.
        pulse_gap(int'(W) - 1, 1000);
        pulse_gap(int'(W), 1000);

        // Randomized trains with occasional glitches.
        for (int i = 0; i < 10; i++) begin
            int w, p, gw;
            w  = int'($urandom_range(2, 40));
            p  = int'($urandom_range(975, 1025));
            gw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            pulse_glitch(w, p, gw);
        end

        // Pin driven: receiver idles.
        pos0 = 1'b0;
        repeat (2) tick();
        check("dis_valid",  32'(pps_valid),  32'd0);
        check("dis_period", period_cnt,      32'd0);
        check("dis_glitch", 32'(glitch_cnt), 32'd0);
        saved = seen_pulse;
        repeat (5) pulse_gap(10, 60);
        check("dis_nopulse", 32'(seen_pulse - saved), 32'd0);
        pos1 = 1'b1;
        repeat (5) tick();
        repeat (3) pulse_gap(20, 1000);
        check("pos1_valid", 32'(pps_valid), 32'd1);

        // Async reset in the middle of a high run.
        pin_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(pps_valid),   32'd0);
        check("arst_pulse",  32'(pps_pulse),   32'd0);
        check("arst_period", period_cnt,       32'd0);
        check("arst_err",    32'(period_err),  32'd0);
        check("arst_miss",   32'(pps_missing), 32'd0);
        check("arst_glitch", 32'(glitch_cnt),  32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        saved = seen_pulse;
        repeat (10) tick();
        pin_in = 1'b0;
        repeat (30) tick();
        check("arst_discard", 32'(seen_pulse - saved), 32'd0);
        pulse_gap(20, 1000);
        check("arst_first",   32'(seen_pulse - saved), 32'd1);
        check("arst_novalid", 32'(pps_valid), 32'd0);
        pulse_gap(20, 1000);
        check("arst_valid2",  32'(pps_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
